// File: rtl/ic_seq_unit_if.sv
// Control/data bundle for ic_seq_unit: enable, mode, load/serial data in; state and event flag out.
interface ic_seq_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] Q;
  logic             Z;

  modport master (output en, output mode, output I, input Q, input Z);
  modport slave  (input en, input mode, input I, output Q, output Z);
endinterface

// File: rtl/ic_seq_unit.sv
// Loadable modulo counter / left shift register with a registered event flag.
// Z pulses on count wrap or carries the bit shifted out of Q's MSB.
module ic_seq_unit #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input logic         clk,
  input logic         rst,
  ic_seq_unit_if.slave bus
);
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  // Terminal count; anything at or above it (e.g. an out-of-range load) wraps to zero.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic             z_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
      z_r <= 1'b0;
    end else if (!bus.en) begin
      z_r <= 1'b0;
    end else begin
      case (bus.mode)
        MODE_HOLD: begin
          z_r <= 1'b0;
        end
        MODE_LOAD: begin
          q_r <= bus.I;
          z_r <= 1'b0;
        end
        MODE_COUNT: begin
          if (q_r >= TERM) begin
            q_r <= '0;
            z_r <= 1'b1;
          end else begin
            q_r <= q_r + WIDTH'(1);
            z_r <= 1'b0;
          end
        end
        MODE_SHIFT: begin
          q_r <= {q_r[WIDTH-2:0], bus.I[0]};
          z_r <= q_r[WIDTH-1];
        end
      endcase
    end
  end

  assign bus.Q = q_r;
  assign bus.Z = z_r;
endmodule

// File: tb/tb_ic_seq_unit.sv
// Scoreboard bench for ic_seq_unit: one instance with MODULUS=10, one with default MODULUS=16.
module tb_ic_seq_unit;
  logic clk = 1'b0;
  logic rst_a, rst_b;

  always #5 clk = ~clk;

  ic_seq_unit_if #(.WIDTH(4)) ifa ();
  ic_seq_unit_if #(.WIDTH(4)) ifb ();

  ic_seq_unit #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  ic_seq_unit #(.WIDTH(4))               dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  typedef struct {
    logic [3:0] q;
    logic       z;
    string      name;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  task automatic compare(input string name, input logic [3:0] aq, input logic az, input exp_t e);
    total++;
    if (aq !== e.q || az !== e.z) begin
      bad++;
      $display("FAIL %s/%s: got Q=%b Z=%b, expected Q=%b Z=%b", name, e.name, aq, az, e.q, e.z);
    end
  endtask

  // Monitors: each edge that consumed a stimulus vector has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        compare("a", ifa.Q, ifa.Z, e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        compare("b", ifb.Q, ifb.Z, e);
      end
    end
  end

  task automatic step_a(input logic r, input logic e, input logic [1:0] m, input logic [3:0] i,
                        input logic [3:0] eq, input logic ez, input string name);
    exp_t x;
    @(negedge clk);
    rst_a = r; ifa.en = e; ifa.mode = m; ifa.I = i;
    x.q = eq; x.z = ez; x.name = name;
    exp_a.push_back(x);
  endtask

  task automatic step_b(input logic r, input logic e, input logic [1:0] m, input logic [3:0] i,
                        input logic [3:0] eq, input logic ez, input string name);
    exp_t x;
    @(negedge clk);
    rst_b = r; ifb.en = e; ifb.mode = m; ifb.I = i;
    x.q = eq; x.z = ez; x.name = name;
    exp_b.push_back(x);
  endtask

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    rst_a = 1'b1; ifa.en = 1'b0; ifa.mode = 2'b00; ifa.I = 4'h0;
    rst_b = 1'b1; ifb.en = 1'b0; ifb.mode = 2'b00; ifb.I = 4'h0;

    // Reset state on both instances, with en/mode active to show rst wins.
    step_a(1, 1, 2'b01, 4'hF, 4'b0000, 0, "reset");
    step_b(1, 1, 2'b10, 4'hF, 4'b0000, 0, "reset");
    step_b(0, 0, 2'b00, 4'h0, 4'b0000, 0, "idle_after_reset");

    // Reset overrides an active COUNT.
    step_a(0, 1, 2'b01, 4'b1010, 4'b1010, 0, "load_1010");
    step_a(1, 1, 2'b10, 4'b0000, 4'b0000, 0, "rst_over_count");

    // Count wrap at MODULUS=10.
    step_a(0, 1, 2'b01, 4'b0111, 4'b0111, 0, "load_0111");
    step_a(0, 1, 2'b10, 4'b0000, 4'b1000, 0, "count_8");
    step_a(0, 1, 2'b10, 4'b0000, 4'b1001, 0, "count_9");
    step_a(0, 1, 2'b10, 4'b0000, 4'b0000, 1, "count_wrap");
    step_a(0, 1, 2'b10, 4'b0000, 4'b0001, 0, "count_after_wrap");

    // Out-of-range load wraps on the next COUNT.
    step_a(0, 1, 2'b01, 4'b1100, 4'b1100, 0, "load_1100_no_check");
    step_a(0, 1, 2'b10, 4'b0000, 4'b0000, 1, "count_out_of_range");

    // Shift with serial-in from I[0]; Z carries old MSB.
    step_a(0, 1, 2'b01, 4'b1001, 4'b1001, 0, "load_1001");
    step_a(0, 1, 2'b11, 4'b0001, 4'b0011, 1, "shift_1");
    step_a(0, 1, 2'b11, 4'b1110, 4'b0110, 0, "shift_2");
    step_a(0, 1, 2'b11, 4'b0000, 4'b1100, 0, "shift_3");
    step_a(0, 1, 2'b11, 4'b0001, 4'b1001, 1, "shift_4");
    step_a(0, 1, 2'b11, 4'b0000, 4'b0010, 1, "shift_run_of_ones");

    // Enable low holds Q and clears Z, even with COUNT selected.
    step_a(0, 1, 2'b01, 4'b0101, 4'b0101, 0, "load_0101");
    for (int k = 0; k < 3; k++) step_a(0, 0, 2'b10, 4'b1111, 4'b0101, 0, "en_low_hold");
    for (int k = 0; k < 2; k++) step_a(0, 1, 2'b00, 4'b1111, 4'b0101, 0, "mode_hold");

    // Reset mid-shift aborts; the next edge resumes from zero in the current mode.
    step_a(0, 1, 2'b01, 4'b1000, 4'b1000, 0, "load_1000");
    step_a(0, 1, 2'b11, 4'b0001, 4'b0001, 1, "shift_out_msb");
    step_a(1, 1, 2'b11, 4'b0001, 4'b0000, 0, "rst_mid_shift");
    step_a(0, 1, 2'b11, 4'b0001, 4'b0001, 0, "shift_from_zero");
    step_a(1, 1, 2'b10, 4'b0000, 4'b0000, 0, "rst_mid_count");
    step_a(0, 1, 2'b10, 4'b0000, 4'b0001, 0, "count_from_zero");

    // Default modulus: all-ones wraps to zero, then a LOAD takes effect immediately.
    step_b(0, 1, 2'b01, 4'b1111, 4'b1111, 0, "load_1111");
    step_b(0, 1, 2'b10, 4'b0000, 4'b0000, 1, "count_wrap16");
    step_b(0, 1, 2'b01, 4'b0011, 4'b0011, 0, "load_0011");
    step_b(0, 1, 2'b01, 4'b1110, 4'b1110, 0, "load_1110");
    step_b(0, 1, 2'b10, 4'b0000, 4'b1111, 0, "count_to_15");
    step_b(0, 1, 2'b10, 4'b0000, 4'b0000, 1, "count_wrap16_again");

    @(negedge clk);
    ifa.en = 1'b0; ifb.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending a=%0d b=%0d, expected 0 0", exp_a.size(), exp_b.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
